trivium_host_ctrl: RTL and testbench

Host-side initiator for the Trivium keystream core. It accepts one request per block: key, IV, a 128-bit data block and a new-key flag. It sequences the core's key-load and IV-load handshakes, waits for the 128-bit keystream, XORs it with the data block, and holds the result until the host accepts it. Encryption and decryption are the same operation. The block sits between the system bus glue and the core and is the only agent that drives the core's input handshake.

---
 rtl/trivium_pkg.sv | 24 ++
 rtl/trivium_wdog.sv | 28 ++
 rtl/trivium_host_ctrl.sv | 171 +++++++++++++++++
 tb/tb_trivium_host_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// Shared types and widths for the Trivium host controller and its keystream core.
package trivium_pkg;

    localparam int KEY_W       = 80;
    localparam int IV_W        = 80;
    localparam int KS_W        = 128;
    localparam int INIT_ROUNDS = 1152;
    localparam int WDOG_W      = 11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_KWAIT = 3'd2,
        S_IV    = 3'd3,
        S_DWAIT = 3'd4,
        S_OUT   = 3'd5
    } state_e;

    // States in which the watchdog is allowed to run.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_KWAIT) || (s == S_IV) || (s == S_DWAIT);
    endfunction

endpackage

// File: rtl/trivium_wdog.sv
// Clearable timeout counter; flags expiry on the cycle whose edge would reach the limit.
module trivium_wdog
    import trivium_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [WDOG_W-1:0] i_limit,
    output logic              o_expired
);

    logic [WDOG_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != i_limit)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Independent of i_clr so the FSM can use it to pick the next state without a loop.
    assign o_expired = i_en && (r_cnt == (i_limit - 1'b1));

endmodule

// File: rtl/trivium_host_ctrl.sv
// Host-side initiator for the Trivium core: key/IV load sequencing, keystream XOR, result hold.
// state   | meaning
// IDLE    | waiting for Start
// KEY     | CoreKrdy strobe
// KWAIT   | waiting for CoreKvld
// IV      | waiting for CoreBSY=0, then CoreDrdy strobe
// DWAIT   | waiting for CoreDvld
// OUT     | Result held until Rrdy
module trivium_host_ctrl
    import trivium_pkg::*;
#(
    parameter int TMO = 2047
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [KEY_W-1:0] Key,
    input  logic [IV_W-1:0]  IV,
    input  logic [KS_W-1:0]  Data,
    input  logic            NewKey,
    input  logic            Start,
    output logic            Busy,
    output logic [KS_W-1:0]  Result,
    output logic            Rvld,
    input  logic            Rrdy,
    output logic            Err,
    output logic [KEY_W-1:0] CoreKin,
    output logic [IV_W-1:0]  CoreDin,
    output logic            CoreKrdy,
    output logic            CoreDrdy,
    output logic            CoreEncDec,
    output logic            CoreEN,
    input  logic [KS_W-1:0]  CoreDout,
    input  logic            CoreBSY,
    input  logic            CoreKvld,
    input  logic            CoreDvld
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_key_loaded;
    logic [KEY_W-1:0]  r_key;
    logic [IV_W-1:0]   r_iv;
    logic [KS_W-1:0]   r_data;
    logic [KS_W-1:0]   r_result;
    logic              r_busy;
    logic              r_rvld;
    logic              r_err;
    logic              r_krdy;
    logic              r_drdy;
    logic              r_en;

    logic              w_accept;
    logic              w_expired;
    logic              w_wd_clr;
    logic              w_wd_en;
    logic              w_busy_nxt;
    logic              w_krdy_nxt;
    logic              w_drdy_nxt;
    logic              w_err_nxt;

    assign w_accept = (r_state == S_IDLE) && Start;
    assign w_wd_clr = (w_state_nxt != r_state);
    assign w_wd_en  = is_wait_state(r_state);

    trivium_wdog u_wdog (
        .i_clk     (CLK),
        .i_rst_n   (RSTn),
        .i_clr     (w_wd_clr),
        .i_en      (w_wd_en),
        .i_limit   (WDOG_W'(TMO)),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_nxt = (NewKey || !r_key_loaded) ? S_KEY : S_IV;
                end
            end
            S_KEY: w_state_nxt = S_KWAIT;
            S_KWAIT: begin
                if (w_expired)     w_state_nxt = S_IDLE;
                else if (CoreKvld) w_state_nxt = S_IV;
            end
            S_IV: begin
                // r_drdy high means the strobe has just been issued this cycle.
                if (w_expired)   w_state_nxt = S_IDLE;
                else if (r_drdy) w_state_nxt = S_DWAIT;
            end
            S_DWAIT: begin
                if (w_expired)     w_state_nxt = S_IDLE;
                else if (CoreDvld) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (Rrdy) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_krdy_nxt = (w_state_nxt == S_KEY);
        w_drdy_nxt = (w_state_nxt == S_IV) && !CoreBSY;
        w_err_nxt  = w_expired;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_key_loaded <= 1'b0;
            r_key        <= '0;
            r_iv         <= '0;
            r_data       <= '0;
            r_result     <= '0;
            r_busy       <= 1'b0;
            r_rvld       <= 1'b0;
            r_err        <= 1'b0;
            r_krdy       <= 1'b0;
            r_drdy       <= 1'b0;
            r_en         <= 1'b0;
        end else begin
            r_en   <= 1'b1;
            r_busy <= w_busy_nxt;
            r_krdy <= w_krdy_nxt;
            r_drdy <= w_drdy_nxt;
            r_err  <= w_err_nxt;

            if (w_accept) begin
                r_key  <= Key;
                r_iv   <= IV;
                r_data <= Data;
            end

            if (w_expired) begin
                r_key_loaded <= 1'b0;
            end else if ((r_state == S_KWAIT) && CoreKvld) begin
                r_key_loaded <= 1'b1;
            end

            if ((r_state == S_DWAIT) && CoreDvld && !w_expired) begin
                r_result <= r_data ^ CoreDout;
                r_rvld   <= 1'b1;
            end else if ((r_state == S_OUT) && Rrdy) begin
                r_rvld <= 1'b0;
            end
        end
    end

    assign Busy       = r_busy;
    assign Result     = r_result;
    assign Rvld       = r_rvld;
    assign Err        = r_err;
    assign CoreKin    = r_key;
    assign CoreDin    = r_iv;
    assign CoreKrdy   = r_krdy;
    assign CoreDrdy   = r_drdy;
    assign CoreEncDec = 1'b0;
    assign CoreEN     = r_en;

endmodule

// File: tb/tb_trivium_host_ctrl.sv
// Self-checking bench for trivium_host_ctrl with a behavioural keystream core model.
module tb_trivium_host_ctrl;

    localparam int TMO   = 2047;
    localparam int M_LAT = 1282;
    localparam logic [127:0] DOUT = 128'h0123456789ABCDEF_FEDCBA9876543210;

    logic         CLK = 1'b0;
    logic         RSTn = 1'b0;
    logic [79:0]  Key, IV;
    logic [127:0] Data;
    logic         NewKey, Start, Rrdy;
    logic         Busy, Rvld, Err;
    logic [127:0] Result;
    logic [79:0]  CoreKin, CoreDin;
    logic         CoreKrdy, CoreDrdy, CoreEncDec, CoreEN;
    logic [127:0] CoreDout;
    logic         CoreBSY, CoreKvld, CoreDvld;

    logic m_kvld, m_dvld, m_bsy;
    logic m_no_dvld = 1'b0;
    logic m_force_dvld = 1'b0;
    logic m_force_kvld = 1'b0;
    int   m_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int c_krdy = 0, c_drdy = 0, c_overlap = 0, c_err = 0, c_rvld_rise = 0;
    logic p_rvld = 1'b0;

    typedef struct {
        logic [79:0]  key;
        logic [79:0]  iv;
        logic [127:0] data;
        logic         newkey;
        logic         exp_kload;
        logic [127:0] exp_res;
        int           bp;
    } vec_t;

    vec_t vecs[7];

    always #5 CLK = ~CLK;

    trivium_host_ctrl #(.TMO(TMO)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .Key(Key), .IV(IV), .Data(Data), .NewKey(NewKey), .Start(Start),
        .Busy(Busy), .Result(Result), .Rvld(Rvld), .Rrdy(Rrdy), .Err(Err),
        .CoreKin(CoreKin), .CoreDin(CoreDin), .CoreKrdy(CoreKrdy), .CoreDrdy(CoreDrdy),
        .CoreEncDec(CoreEncDec), .CoreEN(CoreEN), .CoreDout(CoreDout),
        .CoreBSY(CoreBSY), .CoreKvld(CoreKvld), .CoreDvld(CoreDvld)
    );

    assign CoreDout = DOUT;
    assign CoreBSY  = m_bsy;
    assign CoreKvld = m_kvld | m_force_kvld;
    assign CoreDvld = m_dvld | m_force_dvld;

    // Core model: Kvld one cycle after Krdy; busy for M_LAT cycles after Drdy, then Dvld.
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_kvld <= 1'b0;
            m_dvld <= 1'b0;
            m_bsy  <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_kvld <= CoreKrdy;
            m_dvld <= 1'b0;
            if (CoreDrdy) begin
                m_bsy <= 1'b1;
                m_cnt <= M_LAT - 1;
            end else if (m_bsy) begin
                if (m_cnt == 0) begin
                    m_bsy  <= 1'b0;
                    m_dvld <= !m_no_dvld;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (CoreKrdy) c_krdy++;
        if (CoreDrdy) c_drdy++;
        if (CoreKrdy && CoreDrdy) c_overlap++;
        if (Err) c_err++;
        if (Rvld && !p_rvld) c_rvld_rise++;
        p_rvld = Rvld;
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic start_req(input logic [79:0] k, input logic [79:0] iv_i,
                             input logic [127:0] d, input logic nk);
        Key = k; IV = iv_i; Data = d; NewKey = nk; Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_rvld(input string name);
        int k = 0;
        while (!Rvld && k < 3000) begin
            tick();
            k++;
        end
        chk({name, " rvld arrives"}, Rvld, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int   kb = c_krdy;
        int   db = c_drdy;
        logic stable = 1'b1;
        chk({nm, " idle before start"}, Busy, 1'b0);
        start_req(v.key, v.iv, v.data, v.newkey);
        chk({nm, " busy n+1"}, Busy, 1'b1);
        chk({nm, " krdy n+1"}, CoreKrdy, v.exp_kload);
        chk({nm, " drdy n+1"}, CoreDrdy, !v.exp_kload);
        chk({nm, " core kin"}, CoreKin, v.key);
        chk({nm, " core din"}, CoreDin, v.iv);
        if (v.exp_kload) begin
            tick();
            tick();
            chk({nm, " drdy n+3"}, CoreDrdy, 1'b1);
        end
        wait_rvld(nm);
        chk({nm, " result"}, Result, v.exp_res);
        chk({nm, " krdy count"}, c_krdy - kb, v.exp_kload);
        chk({nm, " drdy count"}, c_drdy - db, 1);
        for (int j = 0; j < v.bp; j++) begin
            tick();
            if (!(Rvld === 1'b1 && Busy === 1'b1 && Result === v.exp_res)) stable = 1'b0;
        end
        if (v.bp > 0) chk({nm, " backpressure hold"}, stable, 1'b1);
        Rrdy = 1'b1;
        tick();
        Rrdy = 1'b0;
        chk({nm, " rvld drop"}, Rvld, 1'b0);
        chk({nm, " busy drop"}, Busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global time limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        int kb, eb, rb, k;

        vecs[0] = '{key: 80'h0, iv: 80'h0, data: {128{1'b1}}, newkey: 1'b1, exp_kload: 1'b1,
                    exp_res: 128'hFEDCBA9876543210_0123456789ABCDEF, bp: 0};
        vecs[1] = '{key: 80'h0, iv: 80'h0, data: 128'h0, newkey: 1'b0, exp_kload: 1'b0,
                    exp_res: 128'h0123456789ABCDEF_FEDCBA9876543210, bp: 0};
        vecs[2] = '{key: 80'h0102030405060708090A, iv: 80'hA0B0C0D0E0F001020304,
                    data: 128'hFFFFFFFFFFFFFFFF_0000000000000000, newkey: 1'b0, exp_kload: 1'b0,
                    exp_res: 128'hFEDCBA9876543210_FEDCBA9876543210, bp: 0};
        vecs[3] = '{key: 80'h1234567890ABCDEF1357, iv: 80'h2468ACE0FDB975310246,
                    data: 128'h0123456789ABCDEF_FEDCBA9876543210, newkey: 1'b1, exp_kload: 1'b1,
                    exp_res: 128'h0, bp: 0};
        vecs[4] = '{key: 80'h1234567890ABCDEF1357, iv: 80'h0, data: 128'h1, newkey: 1'b0,
                    exp_kload: 1'b0, exp_res: 128'h0123456789ABCDEF_FEDCBA9876543211, bp: 20};
        vecs[5] = '{key: 80'hCAFEBABE00112233AABB, iv: 80'h0F1E2D3C4B5A69788796,
                    data: 128'hF0F0F0F0F0F0F0F0_F0F0F0F0F0F0F0F0, newkey: 1'b0, exp_kload: 1'b1,
                    exp_res: 128'hF1D3B597795B3D1F_0E2C4A6886A4C2E0, bp: 0};
        vecs[6] = '{key: 80'h13579BDF02468ACE1122, iv: 80'h99887766554433221100,
                    data: 128'h0000000000000000_FFFFFFFFFFFFFFFF, newkey: 1'b0, exp_kload: 1'b1,
                    exp_res: 128'h0123456789ABCDEF_0123456789ABCDEF, bp: 0};

        Key = '0; IV = '0; Data = '0; NewKey = 1'b0; Start = 1'b0; Rrdy = 1'b0;
        RSTn = 1'b0;
        repeat (3) tick();
        chk("reset outputs", {Busy, Rvld, Err, CoreKrdy, CoreDrdy, CoreEN, CoreEncDec}, 7'b0);
        chk("reset result", Result, 128'h0);
        chk("reset kin/din", {CoreKin, CoreDin}, 160'h0);
        RSTn = 1'b1;
        tick();
        chk("core en after reset", CoreEN, 1'b1);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Spurious CoreDvld while idle.
        m_force_dvld = 1'b1;
        tick();
        m_force_dvld = 1'b0;
        tick();
        tick();
        chk("spurious dvld busy", Busy, 1'b0);
        chk("spurious dvld rvld", Rvld, 1'b0);
        chk("spurious dvld result", Result, vecs[4].exp_res);

        // Start pulses while busy must be ignored.
        kb = c_krdy;
        start_req(80'h1111_2222_3333_4444_5555, 80'h2222, 128'h0, 1'b0);
        chk("ign drdy n+1", CoreDrdy, 1'b1);
        Start = 1'b1; NewKey = 1'b1; Key = {80{1'b1}}; Data = 128'hDEADBEEF;
        repeat (3) tick();
        Start = 1'b0;
        wait_rvld("ign");
        chk("ign result", Result, DOUT);
        chk("ign krdy count", c_krdy - kb, 0);
        chk("ign kin kept", CoreKin, 80'h1111_2222_3333_4444_5555);
        Rrdy = 1'b1;
        tick();
        Rrdy = 1'b0;
        chk("ign busy drop", Busy, 1'b0);

        // Timeout in DWAIT.
        m_no_dvld = 1'b1;
        eb = c_err;
        rb = c_rvld_rise;
        start_req(80'h5, 80'h6, 128'h7, 1'b0);
        chk("to drdy n+1", CoreDrdy, 1'b1);
        k = 0;
        while (!Err && k < TMO + 50) begin
            tick();
            k++;
        end
        chk("to err latency", k, TMO + 1);
        tick();
        chk("to err pulse", Err, 1'b0);
        chk("to busy", Busy, 1'b0);
        chk("to err count", c_err - eb, 1);
        chk("to no rvld", c_rvld_rise - rb, 0);
        m_no_dvld = 1'b0;
        run_vec(vecs[5], "after-timeout");

        // Reset in DWAIT.
        start_req(80'hA5A5A5A5A5A5A5A5A5A5, 80'h5A5A5A5A5A5A5A5A5A5A, 128'h3, 1'b0);
        chk("rst drdy n+1", CoreDrdy, 1'b1);
        repeat (10) tick();
        chk("rst busy before", Busy, 1'b1);
        #2;
        RSTn = 1'b0;
        #1;
        chk("rst async outputs", {Busy, Rvld, Err, CoreKrdy, CoreDrdy, CoreEN, CoreEncDec}, 7'b0);
        chk("rst async result", Result, 128'h0);
        chk("rst async kin/din", {CoreKin, CoreDin}, 160'h0);
        tick();
        RSTn = 1'b1;
        tick();
        // A stray Kvld in IDLE must not mark the key as loaded.
        m_force_kvld = 1'b1;
        tick();
        m_force_kvld = 1'b0;
        tick();
        run_vec(vecs[6], "after-reset");

        chk("krdy/drdy overlap", c_overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
